// File: rtl/wb_arbiter_pkg.sv
// Types, constants and the starvation-counter helper shared by the writeback
// arbiter and its buffer.
`include "diagv2_const.vh"

package wb_arbiter_pkg;

  localparam int ADDR_W   = `RegAddrBits;
  localparam int DATA_W   = `DataBusBits;
  localparam int STARVE_W = 4;

  localparam logic [ADDR_W-1:0]   REG_ZERO   = `RegZero;
  localparam logic [STARVE_W-1:0] STARVE_MAX = 4'd15;

  // Who owns the register file write port this cycle.
  typedef enum logic {
    GRANT_PIPE = 1'b0,
    GRANT_BUF  = 1'b1
  } grant_e;

  // Starvation counter step.
  // The counter restarts whenever the buffer gets served or has nothing to
  // offer. Otherwise the buffer lost to the pipe and the counter climbs,
  // sticking at its maximum.
  function automatic logic [STARVE_W-1:0] starve_update(
    input logic [STARVE_W-1:0] cur,
    input logic                buf_empty,
    input logic                popped
  );
    if (buf_empty || popped) begin
      return '0;
    end else if (cur == STARVE_MAX) begin
      return cur;
    end else begin
      return cur + 4'd1;
    end
  endfunction

endpackage

// File: rtl/diagv2_const.vh
// Shared core-wide constants: register address width, data bus width and the
// hard-wired zero register.
`ifndef DIAGV2_CONST_VH
`define DIAGV2_CONST_VH
`define RegAddrBits 5
`define DataBusBits 32
`define RegZero 5'd0
`endif

// File: rtl/wb_fifo.sv
// Late-writeback buffer for loads and CSR reads.
// Each entry carries a live flag. A younger pipeline write to the same
// register clears that flag, so the stale value drains without being written.
// A CAM over the live entries answers "is this register still pending?".
`include "diagv2_const.vh"

module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [`RegAddrBits-1:0]     push_rd,
  input  logic [`DataBusBits-1:0]     push_data,
  input  logic                        pop,
  input  logic                        kill_en,
  input  logic [`RegAddrBits-1:0]     kill_rd,
  input  logic [`RegAddrBits-1:0]     query_rd,
  output logic                        head_live,
  output logic [`RegAddrBits-1:0]     head_rd,
  output logic [`DataBusBits-1:0]     head_data,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        empty,
  output logic                        full,
  output logic                        busy_hit
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  live;
  logic [DEPTH-1:0]  hit_vec;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = count_q;

  // Entry storage and live flags.
  // Order matters here. Kills are applied first. Then the popped slot is
  // retired, so free slots never look live to the CAM. A same-cycle push
  // lands last, so a new entry survives a matching pipeline write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
      live <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && (rd_mem[i] == kill_rd)) begin
          live[i] <= 1'b0;
        end
      end
      if (pop_ok) begin
        live[rd_ptr] <= 1'b0;
      end
      if (push_ok) begin
        rd_mem[wr_ptr]   <= push_rd;
        data_mem[wr_ptr] <= push_data;
        live[wr_ptr]     <= 1'b1;
      end
    end
  end

  // Read/write pointers wrap naturally because the depth is a power of two.
  // The occupancy count holds steady on a simultaneous push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // CAM lookup against registered entries only.
  // A write being enqueued this cycle is not visible to the lookup yet.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec[i] = live[i] && (rd_mem[i] == query_rd);
    end
  end

  assign busy_hit  = (query_rd != REG_ZERO) && (|hit_vec);
  assign head_live = live[rd_ptr];
  assign head_rd   = rd_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter.
// The in-order pipeline normally owns the single write port. Late results
// (loads, CSR reads) wait in a small buffer and drain whenever the pipe is
// idle. If the buffer has lost STARVE_LIMIT times in a row, the pipe is
// stalled for one cycle so the buffer head can get through.
`include "diagv2_const.vh"

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pipe_valid,
  input  logic [`RegAddrBits-1:0] pipe_rd,
  input  logic [`DataBusBits-1:0] pipe_data,
  output logic                    pipe_stall,
  input  logic                    lsu_valid,
  input  logic [`RegAddrBits-1:0] lsu_rd,
  input  logic [`DataBusBits-1:0] lsu_data,
  output logic                    lsu_ready,
  output logic                    rf_we,
  output logic [`RegAddrBits-1:0] rf_waddr,
  output logic [`DataBusBits-1:0] rf_wdata,
  input  logic [`RegAddrBits-1:0] query_rd,
  output logic                    busy_hit,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  logic [STARVE_W-1:0] starve_cnt;
  logic                force_stall;
  grant_e              grant;
  logic                buf_empty;
  logic                buf_full;
  logic                head_live;
  logic [ADDR_W-1:0]   head_rd;
  logic [DATA_W-1:0]   head_data;
  logic                pipe_we;
  logic                push;
  logic                pop;
  logic                kill_en;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_rd   (lsu_rd),
    .push_data (lsu_data),
    .pop       (pop),
    .kill_en   (kill_en),
    .kill_rd   (pipe_rd),
    .query_rd  (query_rd),
    .head_live (head_live),
    .head_rd   (head_rd),
    .head_data (head_data),
    .count     (fifo_count),
    .empty     (buf_empty),
    .full      (buf_full),
    .busy_hit  (busy_hit)
  );

  // The stall decision depends only on registered state.
  // This keeps lsu_valid out of the pipe_stall path.
  assign force_stall = (starve_cnt >= STARVE_W'(STARVE_LIMIT)) && !buf_empty;
  assign pipe_stall  = force_stall;
  assign pipe_we     = pipe_valid && (pipe_rd != REG_ZERO);

  // The pipe wins unless the buffer has something to write and either the pipe
  // is idle or the buffer has starved long enough to force its turn.
  always_comb begin
    grant = GRANT_PIPE;
    if (!buf_empty && !(pipe_valid && !force_stall)) begin
      grant = GRANT_BUF;
    end
  end

  // Drive the write port from whichever side holds the grant.
  // A buffer grant always pops the head; a killed head pops without writing.
  // A pipe write also kills any older buffered entry for the same register.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = pipe_rd;
    rf_wdata = pipe_data;
    pop      = 1'b0;
    kill_en  = 1'b0;
    if (grant == GRANT_PIPE) begin
      rf_we   = pipe_we && !reset;
      kill_en = pipe_we;
    end else begin
      rf_we    = head_live && !reset;
      rf_waddr = head_rd;
      rf_wdata = head_data;
      pop      = 1'b1;
    end
  end

  // There is no bypass, so a full buffer refuses even in a cycle where it pops.
  // Writes to the zero register are acknowledged but never stored.
  assign lsu_ready = !reset && !buf_full;
  assign push      = lsu_valid && lsu_ready && (lsu_rd != REG_ZERO);

  // Count consecutive cycles in which a waiting buffer lost to the pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_update(starve_cnt, buf_empty, pop);
    end
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: number of load/CSR writeback buffer entries, power of two, 2..8.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive cycles a non-empty buffer may lose before the pipeline is stalled, 1..15.
REQ-003 clk  in  1  single clock; all state changes on posedge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 pipe_valid / pipe_rd / pipe_data  in  1 / `RegAddrBits / `DataBusBits  in-order pipeline writeback request.
REQ-006 pipe_stall  out  1  pipeline must hold its writeback stage this cycle.
REQ-007 lsu_valid / lsu_rd / lsu_data  in  1 / `RegAddrBits / `DataBusBits  late writeback request (load, CSR read).
REQ-008 lsu_ready  out  1  buffer can accept; transfer when lsu_valid && lsu_ready.
REQ-009 rf_we / rf_waddr / rf_wdata  out  1 / `RegAddrBits / `DataBusBits  register file write port.
REQ-010 query_rd  in  `RegAddrBits; busy_hit  out  1  query_rd has a live pending buffered write.
REQ-011 fifo_count  out  $clog2(DEPTH)+1  live-or-killed entries held.

Function
REQ-012 lsu_ready SHALL be 1 iff fifo_count < DEPTH; no bypass, so a full buffer that pops this cycle still refuses.
REQ-013 Accepted requests with lsu_rd == `RegZero SHALL be acknowledged and discarded, never enqueued.
REQ-014 Enqueued entries SHALL drain in FIFO order; minimum enqueue-to-rf_we latency 1 cycle.
REQ-015 force = (starve_cnt >= STARVE_LIMIT) && buffer non-empty; pipe_stall SHALL equal force, combinationally.
REQ-016 Grant each cycle: buffer empty -> pipe; pipe_valid && !force -> pipe; otherwise buffer head.
REQ-017 Pipe grant: rf_we = pipe_valid && pipe_rd != `RegZero, rf_waddr/rf_wdata = pipe fields.
REQ-018 Buffer grant: head popped; rf_we = head live flag, rf_waddr/rf_wdata = head fields.
REQ-019 starve_cnt SHALL increment (saturating at 15) when buffer non-empty and pipe granted, clear on any pop or when buffer empty.
REQ-020 WAW: a pipe grant with rf_we=1 SHALL clear the live flag of every buffered entry whose rd equals pipe_rd; killed entries still pop but do not write.
REQ-021 Entry enqueued in the same cycle as a matching pipe write SHALL NOT be killed (load is younger).
REQ-022 busy_hit SHALL be 1 iff query_rd != `RegZero and some live entry (this cycle's state, excluding same-cycle enqueue) has rd == query_rd.
REQ-023 Simultaneous push and pop SHALL leave fifo_count unchanged; pointers wrap modulo DEPTH.
REQ-024 All outputs combinational from registered state plus current inputs; no combinational path from lsu_valid to pipe_stall.

Reset
REQ-025 While reset is high: fifo_count=0, pointers=0, starve_cnt=0, live flags cleared, rf_we=0, pipe_stall=0, busy_hit=0, lsu_ready=0.
REQ-026 First posedge after reset deassertion: lsu_ready=1; reset mid-drain discards all entries without writing.

Structure
REQ-027 `RegAddrBits, `DataBusBits, `RegZero SHALL come from diagv2_const.vh; no local redefinition.
REQ-028 Buffer storage, pointers, live flags and CAM match SHALL be one sub-module wb_fifo; grant/starve logic in wb_arbiter.

Verification
REQ-029 Empty buffer, pipe_valid rd=5 data=0xAA -> rf_we=1, waddr=5, wdata=0xAA, same cycle, pipe_stall=0.
REQ-030 LSU push rd=7 data=0x11 with pipe idle -> next cycle rf_we=1 waddr=7 wdata=0x11, fifo_count 1->0.
REQ-031 Buffer holds 1 entry, pipe_valid every cycle, STARVE_LIMIT=4 -> 4 pipe writes, then pipe_stall=1 one cycle, buffer entry written.
REQ-032 Two pushes rd=3 -> lsu_ready=0, third push held until a pop; pop order matches push order.
REQ-033 Buffered rd=9 then pipe writes rd=9 data=0x22 -> busy_hit(9) falls to 0, later pop gives rf_we=0; register 9 keeps 0x22.
REQ-034 Reset asserted with 2 entries buffered -> fifo_count=0, rf_we=0 immediately; no buffered write appears afterwards.
